// File: rtl/mcu_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_frame_pkg
//  Description : Shared types and constants for the MCU frame transmitter:
//                controller state encoding, serial bit-frame constants and
//                the channel-index width.
//  Revision    : 1.0  initial release
// ============================================================================
package mcu_frame_pkg;

    // Controller states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Serial bit-frame: one start bit, eight data bits, one stop bit.
    localparam logic c_START_BIT     = 1'b0;
    localparam logic c_STOP_BIT      = 1'b1;
    localparam int   c_BITS_PER_BYTE = 10;

    // Width of the channel index (up to 8 channels).
    localparam int   c_CH_W          = 3;

endpackage : mcu_frame_pkg
`default_nettype wire

// File: rtl/mcu_frame_tx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : Single-byte serialiser. A one-cycle go pulse latches the
//                byte and starts a start/8-data/stop frame, each bit held for
//                CLK_DIV cycles, LSB first. fin pulses in the final cycle of
//                the stop bit. txd idles high.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_tx
    import mcu_frame_pkg::*;
#(
    parameter int CLK_DIV = 24
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    output logic       txd,
    output logic       fin
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]    r_shift;   // remaining data bits followed by the stop bit
    logic          r_active;
    logic          r_txd;

    logic          w_bit_end;
    logic          w_last_bit;

    assign w_bit_end  = r_active && (r_cnt == CW'(CLK_DIV - 1));
    assign w_last_bit = (r_bit == 4'(c_BITS_PER_BYTE - 1));

    // Bit timing and shift register; a new go restarts the frame from the start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_txd    <= c_STOP_BIT;
        end else if (go) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= {c_STOP_BIT, tx_byte};
            r_txd    <= c_START_BIT;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (w_last_bit) begin
                    r_active <= 1'b0;
                    r_txd    <= c_STOP_BIT;
                end else begin
                    r_txd   <= r_shift[0];
                    r_shift <= {c_STOP_BIT, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign txd = r_txd;
    assign fin = w_bit_end && w_last_bit;

endmodule : uart_byte_tx
`default_nettype wire

// File: rtl/mcu_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_frame_tx
//  Description : Round-robin multi-channel frame transmitter. Grants one
//                requesting channel, snapshots its header/length/payload and
//                sends header plus min(len, MAX_BYTES) payload bytes on a
//                serial line, each byte preceded by GAP_CYC idle-high cycles.
//                Optional feature macro: MCU_FRAME_CHECKSUM_EN appends an XOR
//                checksum byte after the payload.
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_frame_tx
    import mcu_frame_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 24,
    parameter int GAP_CYC   = 200
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH*8-1:0]         hdr,
    input  logic [NUM_CH*5-1:0]         len,
    input  logic [NUM_CH*MAX_BYTES*8-1:0] payload,
    output logic [NUM_CH-1:0]           done,
    output logic                        busy,
    output logic [2:0]                  cur_ch,
    output logic                        txd
);

    localparam int CNT_MAX = (GAP_CYC > 8 * CLK_DIV) ? GAP_CYC : 8 * CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef MCU_FRAME_CHECKSUM_EN
    localparam logic [4:0] c_EXTRA = 5'd1;
`else
    localparam logic [4:0] c_EXTRA = 5'd0;
`endif

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [c_CH_W-1:0]        r_cur;
    logic [c_CH_W-1:0]        r_ptr;      // first channel examined at next arbitration
    logic [7:0]               r_hdr;
    logic [MAX_BYTES*8-1:0]   r_pay;
    logic [4:0]               r_idx;      // byte being sent: 0 = header
    logic [4:0]               r_last;     // index of the final byte of the frame

    logic                     w_gnt_vld;
    logic [c_CH_W-1:0]        w_gnt;
    logic [7:0]               w_hdr_g;
    logic [4:0]               w_len_g;
    logic [4:0]               w_len_clip;
    logic [MAX_BYTES*8-1:0]   w_pay_g;
    logic [7:0]               w_byte;
    logic                     w_go;
    logic                     w_fin;

    // Round-robin search starting at r_ptr; the lowest offset with a request wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % NUM_CH]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = c_CH_W'((int'(r_ptr) + i) % NUM_CH);
            end
        end
    end

    assign w_hdr_g    = hdr[int'(w_gnt) * 8 +: 8];
    assign w_len_g    = len[int'(w_gnt) * 5 +: 5];
    assign w_pay_g    = payload[int'(w_gnt) * MAX_BYTES * 8 +: MAX_BYTES * 8];
    assign w_len_clip = (w_len_g > 5'(MAX_BYTES)) ? 5'(MAX_BYTES) : w_len_g;

    // State register and cycle counter; the counter restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    // Next-state logic; go is issued in the last GAP cycle so the start bit
    // appears exactly as the controller enters START.
    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_gnt_vld) w_next = ST_GAP;
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_next = ST_START;
                    w_go   = 1'b1;
                end
            end
            ST_START: if (r_cnt == CNT_W'(CLK_DIV - 1))     w_next = ST_DATA;
            ST_DATA:  if (r_cnt == CNT_W'(8 * CLK_DIV - 1)) w_next = ST_STOP;
            ST_STOP:  if (w_fin) w_next = (r_idx == r_last) ? ST_DONE : ST_GAP;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Grant snapshot, round-robin pointer and byte sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur  <= '0;
            r_ptr  <= '0;
            r_hdr  <= '0;
            r_pay  <= '0;
            r_idx  <= '0;
            r_last <= '0;
        end else if (r_state == ST_IDLE && w_gnt_vld) begin
            r_cur  <= w_gnt;
            r_ptr  <= (int'(w_gnt) == NUM_CH - 1) ? '0 : w_gnt + 1'b1;
            r_hdr  <= w_hdr_g;
            r_pay  <= w_pay_g;
            r_idx  <= '0;
            r_last <= w_len_clip + c_EXTRA;
        end else if (r_state == ST_STOP && w_fin && r_idx != r_last) begin
            r_idx  <= r_idx + 5'd1;
        end
    end

`ifdef MCU_FRAME_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR of every byte handed to the serialiser in this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE && w_gnt_vld) begin
            r_csum <= '0;
        end else if (w_go) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

    // Select the byte for the current index: header, payload, then checksum.
    always_comb begin
        w_byte = r_hdr;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (r_idx == 5'(k + 1)) w_byte = r_pay[k * 8 +: 8];
        end
`ifdef MCU_FRAME_CHECKSUM_EN
        if (r_idx != 5'd0 && r_idx == r_last) w_byte = r_csum;
`endif
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .go      (w_go),
        .tx_byte (w_byte),
        .txd     (txd),
        .fin     (w_fin)
    );

    // One-cycle completion pulse on the served channel.
    always_comb begin
        done = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            done[c] = (r_state == ST_DONE) && (int'(r_cur) == c);
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign cur_ch = r_cur;

endmodule : mcu_frame_tx
`default_nettype wire
